spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port sclk, input, 1, SPI serial clock; asynchronous to clk; mode 0.
REQ-004 SHALL have port copi, input, 1, controller-out/peripheral-in data; asynchronous to clk.
REQ-005 SHALL have port ncs, input, 1, chip select; active-low; asynchronous to clk.
REQ-006 SHALL have port cipo, output, 1, peripheral-out data; tied 0 unless SPI_READBACK_EN is defined.
REQ-007 SHALL have ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, each output, 8, register value driven to the PWM block.
REQ-008 SHALL have port txn_done, output, 1, one-clk pulse on each committed write or completed read.

Function
REQ-009 SHALL pass sclk, copi and ncs through a 2-FF synchronizer each; edge detection SHALL use synchronized values only.
REQ-010 SHALL sample copi on synchronized sclk rising edges while synchronized ncs is low, MSB first.
REQ-011 SHALL use a 16-bit frame: bit15 = R/W (1 = write), bits14:8 = address (7 bits), bits7:0 = data.
REQ-012 SHALL map addresses as follows: 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle.
REQ-013 SHALL ignore writes to addresses 0x05-0x7F: no register change, txn_done still pulses.
REQ-014 SHALL implement FSM states IDLE, RECV, FULL, OVERRUN, WAIT_IDLE.
REQ-015 SHALL transition IDLE->RECV on a synchronized ncs falling edge, clearing the bit counter (5-bit) and the shift register.
REQ-016 SHALL transition RECV->FULL when the 16th bit is sampled.
REQ-017 SHALL transition FULL->OVERRUN on any further sclk rising edge.
REQ-018 SHALL commit a write in FULL on the synchronized ncs rising edge, then return to IDLE.
REQ-019 SHALL make the committed register visible on the clk edge after the synchronized ncs rise is detected: at most 4 clk cycles after the raw ncs rise.
REQ-020 SHALL abort a frame when ncs rises in RECV (<16 bits) or in OVERRUN (>16 bits): no register change, no txn_done, return to IDLE.
REQ-021 SHALL, when an ncs rise and an sclk rise are detected in the same clk cycle, give ncs priority and discard the concurrent bit.
REQ-022 SHALL support sclk frequency <= clk/8; behaviour at higher sclk rates is undefined.

Reset
REQ-023 SHALL, while rst is high, clear all five registers to 0x00, cipo to 0, txn_done to 0, the counter and shift register to 0, and all synchronizer flops to idle levels (ncs=1, sclk=0, copi=0).
REQ-024 SHALL, on reset mid-frame, discard the partial frame.
REQ-025 SHALL, if synchronized ncs is low when rst deasserts, enter WAIT_IDLE and stay there until synchronized ncs is high, then enter IDLE; no mid-frame start.

Configuration
REQ-026 SHALL, with SPI_READBACK_EN defined, treat a frame with bit15=0 as a read.
REQ-027 SHALL, for a read, on the 8th sclk rise load the addressed register (0x00 for unmapped addresses) into an 8-bit output shifter.
REQ-028 SHALL, for a read, drive cipo with the shifter MSB and shift on each subsequent synchronized sclk falling edge.
REQ-029 SHALL, for a read, pulse txn_done on the ncs rise in FULL.
REQ-030 SHALL, without SPI_READBACK_EN, hold cipo at 0 and discard read frames like aborted frames, with no txn_done.

Structure
REQ-031 SHALL place the FSM state enum, address constants ADDR_EN_OUT_LO..ADDR_DUTY, FRAME_BITS=16 and NUM_REGS=5 in the shared package spi_pkg.
REQ-032 SHALL implement the 2-FF synchronizer as the sub-module spi_sync, instantiated three times.

Verification
REQ-033 SHALL cover: write 0x8455 (addr 0x04, data 0x55) -> pwm_duty_cycle=0x55 within 4 clk of the ncs rise; one txn_done pulse; other registers unchanged.
REQ-034 SHALL cover: write 0x80F0 then 0x81A5 -> en_reg_out_7_0=0xF0, en_reg_out_15_8=0xA5; two txn_done pulses.
REQ-035 SHALL cover: 12-bit frame 0x830 then ncs rise, and a separate 17-bit frame -> all registers unchanged, no txn_done.
REQ-036 SHALL cover: write 0xFF11 (addr 0x7F) -> no register change, one txn_done pulse.
REQ-037 SHALL cover: rst pulse mid-frame with ncs held low -> registers 0x00; remaining sclk edges ignored until ncs goes high; next write 0x8233 -> en_reg_pwm_7_0=0x33.
REQ-038 SHALL cover, with SPI_READBACK_EN: write 0x8455, then read 0x0400 -> cipo shifts 0b01010101 MSB first on bits 8-15; without the macro, cipo stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register peripheral.
package spi_pkg;

    localparam int unsigned FRAME_BITS     = 16;
    localparam int unsigned NUM_REGS       = 5;
    localparam int unsigned ADDR_W         = 7;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned CNT_W          = 5;
    localparam int unsigned READ_LOAD_BITS = 8;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        FULL,
        OVERRUN,
        WAIT_IDLE
    } state_e;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input with a configurable idle level.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-register peripheral driving the PWM block configuration.
// Define SPI_READBACK_EN to enable register reads over cipo.
module spi_peripheral
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_done
);

    localparam logic [1:0] SETTLE_CYCLES = 2'd2;

    logic sclk_s, copi_s, ncs_s;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst(rst), .d(copi), .q(copi_s));
    spi_sync #(.RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst(rst), .d(ncs),  .q(ncs_s));

    state_e                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]               shift_q, shift_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]     regs_q, regs_d;
    logic                                sclk_prev_q, sclk_prev_d;
    logic                                ncs_prev_q, ncs_prev_d;
    logic [1:0]                          settle_q, settle_d;
    logic                                txn_done_q, txn_done_d;
    logic                                sclk_rise, ncs_rise, ncs_fall;
    frame_t                              frame;

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] out_shift_q, out_shift_d;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_req;
    logic              sclk_fall;

    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // Header byte as it will stand once the 8th bit is shifted in.
    assign rd_req    = ~shift_q[READ_LOAD_BITS-2];
    assign rd_addr   = {shift_q[ADDR_W-2:0], copi_s};

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_EN_OUT_LO: rd_data = regs_q[0];
            ADDR_EN_OUT_HI: rd_data = regs_q[1];
            ADDR_EN_PWM_LO: rd_data = regs_q[2];
            ADDR_EN_PWM_HI: rd_data = regs_q[3];
            ADDR_DUTY:      rd_data = regs_q[4];
            default:        rd_data = '0;
        endcase
    end
`endif

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign frame     = frame_t'(shift_q);

    // Next-state, datapath and commit logic; ncs edges take priority over sclk.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        regs_d      = regs_q;
        txn_done_d  = 1'b0;
        sclk_prev_d = sclk_s;
        ncs_prev_d  = ncs_s;
        settle_d    = (settle_q == SETTLE_CYCLES) ? settle_q : settle_q + 2'd1;
`ifdef SPI_READBACK_EN
        out_shift_d = out_shift_q;
        // MSB is held through the first fall so the controller samples it on bit 8.
        if (sclk_fall && (cnt_q > CNT_W'(READ_LOAD_BITS)))
            out_shift_d = {out_shift_q[DATA_W-2:0], 1'b0};
`endif

        case (state_q)
            WAIT_IDLE: begin
                if ((settle_q == SETTLE_CYCLES) && ncs_s)
                    state_d = IDLE;
            end
            IDLE: begin
                if (ncs_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            RECV: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_BITS - 1))
                        state_d = FULL;
`ifdef SPI_READBACK_EN
                    if ((cnt_q == CNT_W'(READ_LOAD_BITS - 1)) && rd_req)
                        out_shift_d = rd_data;
`endif
                end
            end
            FULL: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                    if (frame.rw) begin
                        txn_done_d = 1'b1;
                        case (frame.addr)
                            ADDR_EN_OUT_LO: regs_d[0] = frame.data;
                            ADDR_EN_OUT_HI: regs_d[1] = frame.data;
                            ADDR_EN_PWM_LO: regs_d[2] = frame.data;
                            ADDR_EN_PWM_HI: regs_d[3] = frame.data;
                            ADDR_DUTY:      regs_d[4] = frame.data;
                            default:        ;
                        endcase
                    end
`ifdef SPI_READBACK_EN
                    else begin
                        txn_done_d = 1'b1;
                    end
`endif
                end else if (sclk_rise) begin
                    state_d = OVERRUN;
                end
            end
            OVERRUN: begin
                if (ncs_rise)
                    state_d = IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase

`ifdef SPI_READBACK_EN
        if (state_d == IDLE)
            out_shift_d = '0;
`endif
    end

    // Reset always lands in WAIT_IDLE so a frame already in flight is never joined.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            regs_q      <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            settle_q    <= '0;
            txn_done_q  <= 1'b0;
`ifdef SPI_READBACK_EN
            out_shift_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            regs_q      <= regs_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            settle_q    <= settle_d;
            txn_done_q  <= txn_done_d;
`ifdef SPI_READBACK_EN
            out_shift_q <= out_shift_d;
`endif
        end
    end

`ifdef SPI_READBACK_EN
    assign cipo = out_shift_q[DATA_W-1];
`else
    assign cipo = 1'b0;
`endif

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign txn_done        = txn_done_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed scoreboard bench for spi_peripheral; follows SPI_READBACK_EN like the RTL.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo;
    logic [7:0] r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;
    logic       txn_done;

    spi_peripheral dut (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .cipo            (cipo),
        .en_reg_out_7_0  (r_out_lo),
        .en_reg_out_15_8 (r_out_hi),
        .en_reg_pwm_7_0  (r_pwm_lo),
        .en_reg_pwm_15_8 (r_pwm_hi),
        .pwm_duty_cycle  (r_duty),
        .txn_done        (txn_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [39:0] regs;
        logic [31:0] done;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    logic [7:0]  exp_regs [5];
    exp_t        sb_q [$];
    logic [15:0] cipo_cap;

    // Count txn_done pulses, sampled away from the active edge.
    always @(negedge clk) if (txn_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] pack_regs();
        return {exp_regs[4], exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
    endfunction

    // Reference behaviour of one completed frame of n bits.
    task automatic model(input logic [31:0] bits, input int n);
        logic [6:0] addr;
        addr = bits[14:8];
        if (n == 16) begin
            if (bits[15]) begin
                exp_done++;
                if (addr < 7'd5) exp_regs[addr[2:0]] = bits[7:0];
            end
`ifdef SPI_READBACK_EN
            else exp_done++;
`endif
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.regs = pack_regs();
        e.done = 32'(exp_done);
        sb_q.push_back(e);
    endtask

    task automatic verify(input string tag);
        exp_t e;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, ".out_lo"}, 32'(r_out_lo), 32'(e.regs[7:0]));
            check({tag, ".out_hi"}, 32'(r_out_hi), 32'(e.regs[15:8]));
            check({tag, ".pwm_lo"}, 32'(r_pwm_lo), 32'(e.regs[23:16]));
            check({tag, ".pwm_hi"}, 32'(r_pwm_hi), 32'(e.regs[31:24]));
            check({tag, ".duty"},   32'(r_duty),   32'(e.regs[39:32]));
            check({tag, ".done"},   32'(done_cnt), e.done);
        end
    endtask

    task automatic clock_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            #50;
            cipo_cap = {cipo_cap[14:0], cipo};
            sclk = 1'b1;
            #50;
            sclk = 1'b0;
        end
    endtask

    // Drive a full frame, then check 4 clk after the ncs rise.
    task automatic frame(input string tag, input logic [31:0] bits, input int n);
        model(bits, n);
        push_expect();
        @(posedge clk);
        #1;
        cipo_cap = '0;
        ncs = 1'b0;
        #50;
        clock_bits(bits, n);
        #50;
        ncs = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        verify(tag);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;

        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        push_expect();
        verify("reset");
        check("reset.cipo", 32'(cipo), 32'd0);
        check("reset.txn_done", 32'(txn_done), 32'd0);

        frame("duty", 32'h8455, 16);
        frame("out_lo", 32'h80F0, 16);
        frame("out_hi", 32'h81A5, 16);
        frame("short12", 32'h0830, 12);
        frame("long17", 32'h1_08AB, 17);
        frame("unmapped", 32'hFF11, 16);
        frame("pwm_hi", 32'h83C3, 16);

        // Reset mid-frame with ncs held low; a full frame afterwards must be ignored.
        @(posedge clk);
        #1;
        ncs = 1'b0;
        #50;
        clock_bits(32'h3F, 6);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
        clock_bits(32'h8477, 16);
        #50;
        ncs = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push_expect();
        verify("rst_mid");
        repeat (4) @(posedge clk);
        frame("after_rst", 32'h8233, 16);

        frame("rb_write", 32'h8455, 16);
        frame("rb_read", 32'h0400, 16);
`ifdef SPI_READBACK_EN
        check("rb_cipo", 32'(cipo_cap), {24'h0, exp_regs[4]});
`else
        check("rb_cipo", 32'(cipo_cap), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
